// File: rtl/md_sequencer_if.sv
// E/D-stage operand and control bundle between the pipeline and the
// multiply/divide sequencer. The master is the pipeline side, the slave is the unit.
interface md_sequencer_if;
    logic [31:0] InstrE;
    logic [31:0] InstrD;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic        StallMD;
    logic [31:0] MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output InstrE, InstrD, A, B,
        input  Start, Busy, StallMD, MDOut, HI, LO
    );

    modport slave (
        input  InstrE, InstrD, A, B,
        output Start, Busy, StallMD, MDOut, HI, LO
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. A fixed-latency busy
// counter stands in for the iterative datapath; the result is committed on
// the last busy edge from operands captured at the start edge.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    md_sequencer_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_e;
    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic is_md(input logic [31:0] instr);
        return (instr[31:26] == 6'b0) &&
               (instr[5:0] inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                   F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    state_e        state;
    op_e           op_q;
    logic [CW-1:0] count;
    logic          busy;
    logic [31:0]   a_q, b_q, hi, lo;

    logic        special_e, is_muldiv_e, is_div_e, start;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, q_s, r_s, q_u, r_u, res_hi, res_lo;
    logic        div_zero;
    logic        unused_bits;

    // E-stage decode and start qualification
    always_comb begin
        special_e   = (md.InstrE[31:26] == 6'b0);
        is_muldiv_e = special_e && (md.InstrE[5:0] inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
        is_div_e    = md.InstrE[1];
        start       = is_muldiv_e && !busy;
    end

    // Result datapath from captured operands; divisor forced to 1 on zero so
    // the unused quotient never goes X (the write is suppressed anyway)
    always_comb begin
        div_zero = (b_q == 32'd0);
        div_b    = div_zero ? 32'd1 : b_q;
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        q_s      = $signed(a_q) / $signed(div_b);
        r_s      = $signed(a_q) % $signed(div_b);
        q_u      = a_q / div_b;
        r_u      = a_q % div_b;
        res_hi   = prod_s[63:32];
        res_lo   = prod_s[31:0];
        case (op_q)
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  ;
        endcase
    end

    // Sequencer FSM: start capture, busy countdown, HI/LO commit and moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= md.A;
                        b_q   <= md.B;
                        op_q  <= op_e'(md.InstrE[1:0]);
                        count <= is_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (special_e && md.InstrE[5:0] == F_MTHI) begin
                        hi <= md.A;
                    end else if (special_e && md.InstrE[5:0] == F_MTLO) begin
                        lo <= md.A;
                    end
                end
                RUN: begin
                    if (count == CW'(1)) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!((op_q == OP_DIV || op_q == OP_DIVU) && div_zero)) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs: HI/LO read port and D-stage stall request
    always_comb begin
        md.Start   = start;
        md.Busy    = busy;
        md.HI      = hi;
        md.LO      = lo;
        md.StallMD = is_md(md.InstrD) && (busy || start);
        md.MDOut   = 32'd0;
        if (special_e && md.InstrE[5:0] == F_MFHI) md.MDOut = hi;
        if (special_e && md.InstrE[5:0] == F_MFLO) md.MDOut = lo;
    end

    assign unused_bits = ^{md.InstrE[25:6], md.InstrD[25:6]};
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Sits beside the E-stage ALU and owns the HI/LO register pair.
- Decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage instruction and runs a fixed-latency busy counter.
- Drives the D-stage stall request that holds HI/LO-dependent instructions until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- InstrE  input  32  instruction currently in E stage.
- InstrD  input  32  instruction currently in D stage.
- A  input  32  E-stage rs operand (already forwarded).
- B  input  32  E-stage rt operand (already forwarded).
- Start  output  1  combinational; E instr is mult/multu/div/divu and Busy=0.
- Busy  output  1  registered; operation in progress.
- StallMD  output  1  combinational stall request to the hazard unit.
- MDOut  output  32  combinational; HI for mfhi, LO for mflo, 0 otherwise.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Decode: op = special (000000) with these functs:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - isMD(x) is true for any of these eight.
- Reset (async, any time, including mid-operation):
  - Busy=0, counter=0, HI=0, LO=0.
  - Captured operands and pending op discarded; no late HI/LO write after reset release.
- Start cycle (Start=1):
  - At the clock edge, capture A, B and the op kind.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from the next cycle.
- States:
  - IDLE (Busy=0) -> RUN on Start.
  - RUN: counter decrements each edge. On the edge where counter==1, write the result to HI/LO, clear Busy, go to IDLE.
  - Busy is high for exactly N cycles after the start cycle.
  - A new Start is accepted on the first cycle Busy=0.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - For both, {HI,LO} = product.
  - div: signed, quotient truncated toward zero; LO=quotient, HI=remainder (remainder takes the sign of the dividend).
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divide by zero: the full busy latency still runs; HI and LO are NOT written.
- mthi/mtlo in E with Busy=0 and no Start: HI (or LO) <= A at that edge.
- mthi/mtlo in E while Busy=1: ignored, HI/LO unchanged. The stall rule prevents this in legal flow.
- mult/div in E while Busy=1: Start=0, instruction ignored. The stall rule prevents this in legal flow.
- mfhi/mflo in E: MDOut reads the current registered HI/LO, with no bypass from a same-edge write.
- StallMD = isMD(InstrD) && (Busy || Start).
  - Covers the start cycle, so the dependent instruction never enters E while the unit is occupied.
  - Drops in the same cycle Busy falls.
- Non-MD instructions in D or E never stall and never touch HI/LO.

Test Plan:
1. mult, A=0xFFFFFFFD (-3), B=7 -> Start=1 for 1 cycle; Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
2. divu, A=100, B=7 -> Busy 10 cycles; then LO=14, HI=2. div, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. mult in E with mflo in D -> StallMD=1 on the start cycle and all 5 busy cycles, 0 on the cycle after. A following mflo then gives MDOut=new LO.
4. mthi in E with A=0x12345678, idle -> HI=0x12345678 after the edge. Next-cycle mfhi -> MDOut=0x12345678; mflo -> MDOut equals the unchanged LO.
5. HI=0xAAAA0000, LO=0x0000BBBB; div with B=0 -> Busy 10 cycles; HI/LO unchanged. An immediately following divu 9/3 -> LO=3, HI=0.
6. Reset pulse in the 3rd busy cycle of a mult -> Busy=0 immediately (asynchronous), HI=LO=0. No HI/LO change in the following 10 cycles. StallMD=0 with mfhi in D.
